dkong_vram_cpu_if: RTL and testbench

- CPU-side initiator for the tile VRAM port. It decodes Z80 accesses to the VRAM window and holds the CPU with WAITn while the video side owns VRAM (VRAMBUSYn low).
- Once granted, it drives the VRAM address, data and RD/WR strobes for a fixed number of enabled cycles. It latches read data and then releases the CPU.
- It sits between the Z80 bus and the VRAM block, and is the only driver of the VRAM CPU-side strobes.

---
 rtl/dkong_pkg.sv | 31 +++
 rtl/dkong_vram_cpu_if_if.sv | 43 ++++
 rtl/dkong_vram_cpu_if.sv | 154 +++++++++++++++
 tb/tb_dkong_vram_cpu_if.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_pkg.sv
// Shared definitions for the Donkey Kong CPU-side VRAM access path.
package dkong_pkg;

    localparam int unsigned CPU_AW  = 16;
    localparam int unsigned VRAM_AW = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TAG_W   = CPU_AW - VRAM_AW;

    // First CPU address of the 1 KiB tile VRAM window
    localparam logic [CPU_AW-1:0] VRAM_BASE = 16'h7400;

    // Access sequencer state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_ACCESS    = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // One latched CPU request: VRAM offset, write data, direction
    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [DATA_W-1:0]  wdata;
        logic               wr;
    } vram_req_t;

    // True when the upper CPU address bits select the VRAM window
    function automatic logic vram_win_hit(input logic [TAG_W-1:0] ab_tag,
                                          input logic [TAG_W-1:0] base_tag);
        return ab_tag == base_tag;
    endfunction

endpackage

// File: rtl/dkong_vram_cpu_if_if.sv
// Z80 bus and VRAM CPU-port signals seen by the VRAM access initiator.
interface dkong_vram_cpu_if_if;
    import dkong_pkg::*;

    // Z80 side
    logic [CPU_AW-1:0]  I_CPU_AB;
    logic [DATA_W-1:0]  I_CPU_DB;
    logic               I_CPU_MREQn;
    logic               I_CPU_RDn;
    logic               I_CPU_WRn;
    logic [DATA_W-1:0]  O_CPU_DB;
    logic               O_CPU_WAITn;

    // VRAM side
    logic               I_VRAMBUSYn;
    logic [DATA_W-1:0]  I_VRAM_DB;
    logic [VRAM_AW-1:0] O_VRAM_AB;
    logic [DATA_W-1:0]  O_VRAM_DB;
    logic               O_VRAM_WRn;
    logic               O_VRAM_RDn;

    // Status
    logic               O_TMO;

    // Environment view: drives CPU requests and VRAM status/data
    modport master (
        output I_CPU_AB, I_CPU_DB, I_CPU_MREQn, I_CPU_RDn, I_CPU_WRn,
        output I_VRAMBUSYn, I_VRAM_DB,
        input  O_CPU_DB, O_CPU_WAITn,
        input  O_VRAM_AB, O_VRAM_DB, O_VRAM_WRn, O_VRAM_RDn,
        input  O_TMO
    );

    // Initiator view
    modport slave (
        input  I_CPU_AB, I_CPU_DB, I_CPU_MREQn, I_CPU_RDn, I_CPU_WRn,
        input  I_VRAMBUSYn, I_VRAM_DB,
        output O_CPU_DB, O_CPU_WAITn,
        output O_VRAM_AB, O_VRAM_DB, O_VRAM_WRn, O_VRAM_RDn,
        output O_TMO
    );

endinterface

// File: rtl/dkong_vram_cpu_if.sv
// CPU-side initiator for the tile VRAM port: decodes Z80 accesses to the
// VRAM window, holds the CPU on WAITn while video owns VRAM, then runs a
// fixed-length strobed access and returns read data.
module dkong_vram_cpu_if
    import dkong_pkg::*;
#(
    parameter logic [CPU_AW-1:0] BASE_ADDR = VRAM_BASE,
    parameter int unsigned       ACC_CYC   = 2,     // >= 2: read data lags address by one cycle
    parameter int unsigned       TMO_CYC   = 1023
) (
    input  logic                    CLK_24M,
    input  logic                    I_RESETn,
    input  logic                    CLK_EN,
    dkong_vram_cpu_if_if.slave      bus
);

    localparam int unsigned       ACW      = $clog2(ACC_CYC);
    localparam int unsigned       TW       = $clog2(TMO_CYC + 1);
    localparam logic [ACW-1:0]    ACC_LOAD = ACW'(ACC_CYC - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TMO_CYC);

    logic [1:0]         state_q, state_d;
    vram_req_t          req_q, req_d;
    logic [ACW-1:0]     acc_cnt_q, acc_cnt_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               tmo_q, tmo_d;
    logic               wrn_q, wrn_d;
    logic               rdn_q, rdn_d;
    logic [VRAM_AW-1:0] vab_q, vab_d;
    logic [DATA_W-1:0]  vdb_q, vdb_d;
    logic [DATA_W-1:0]  cdb_q, cdb_d;
    logic               hit_c;
    logic               wait_c;

    // Window decode of a Z80 memory read or write
    assign hit_c = !bus.I_CPU_MREQn && (!bus.I_CPU_RDn || !bus.I_CPU_WRn) &&
                   vram_win_hit(bus.I_CPU_AB[CPU_AW-1:VRAM_AW], BASE_ADDR[CPU_AW-1:VRAM_AW]);

    // Hold the CPU from the decode cycle until the access has finished
    assign wait_c = (hit_c && (state_q == ST_IDLE)) ||
                    (state_q == ST_WAIT_BUSY) || (state_q == ST_ACCESS);

    // State register
    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q <= ST_IDLE;
        end else if (CLK_EN) begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        acc_cnt_d = acc_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        cdb_d     = cdb_q;
        vab_d     = vab_q;
        wrn_d     = 1'b1;
        rdn_d     = 1'b1;
        vdb_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (hit_c) begin
                    req_d.addr  = bus.I_CPU_AB[VRAM_AW-1:0];
                    req_d.wdata = bus.I_CPU_DB;
                    req_d.wr    = !bus.I_CPU_WRn;   // RDn and WRn both low counts as a write
                    state_d     = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.I_VRAMBUSYn) begin
                    acc_cnt_d = ACC_LOAD;
                    state_d   = ST_ACCESS;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_d     = 1'b1;
                    acc_cnt_d = ACC_LOAD;
                    state_d   = ST_ACCESS;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_ACCESS: begin
                // Committed: VRAMBUSYn is ignored until the strobe completes
                if (acc_cnt_q == '0) begin
                    if (!req_q.wr) begin
                        cdb_d = bus.I_VRAM_DB;
                    end
                    state_d = ST_DONE;
                end else begin
                    acc_cnt_d = acc_cnt_q - ACW'(1);
                end
            end
            ST_DONE: begin
                if (bus.I_CPU_MREQn) begin
                    cdb_d     = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes, address and write data follow the state being entered
        if (state_d == ST_ACCESS) begin
            vab_d = req_d.addr;
            if (req_d.wr) begin
                wrn_d = 1'b0;
                vdb_d = req_d.wdata;
            end else begin
                rdn_d = 1'b0;
            end
        end
    end

    // Datapath and output registers, frozen while CLK_EN is low
    always_ff @(posedge CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            req_q     <= '0;
            acc_cnt_q <= '0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            wrn_q     <= 1'b1;
            rdn_q     <= 1'b1;
            vab_q     <= '0;
            vdb_q     <= '0;
            cdb_q     <= '0;
        end else if (CLK_EN) begin
            req_q     <= req_d;
            acc_cnt_q <= acc_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
            wrn_q     <= wrn_d;
            rdn_q     <= rdn_d;
            vab_q     <= vab_d;
            vdb_q     <= vdb_d;
            cdb_q     <= cdb_d;
        end
    end

    assign bus.O_CPU_WAITn = !I_RESETn || !wait_c;
    assign bus.O_CPU_DB    = cdb_q;
    assign bus.O_VRAM_AB   = vab_q;
    assign bus.O_VRAM_DB   = vdb_q;
    assign bus.O_VRAM_WRn  = wrn_q;
    assign bus.O_VRAM_RDn  = rdn_q;
    assign bus.O_TMO       = tmo_q;

endmodule

// File: tb/tb_dkong_vram_cpu_if.sv
// Directed bench for dkong_vram_cpu_if: a default-timeout instance drives a
// small VRAM model, a second instance with a short timeout shares its inputs.
module tb_dkong_vram_cpu_if;
    import dkong_pkg::*;

    logic CLK_24M = 1'b0;
    logic I_RESETn;
    logic CLK_EN;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit slow        = 1'b0;

    logic [7:0] vram_mem [0:1023];
    logic       pre_we;
    logic [9:0] pre_a;
    logic [7:0] pre_d;

    dkong_vram_cpu_if_if bus_a ();
    dkong_vram_cpu_if_if bus_b ();

    dkong_vram_cpu_if #(.BASE_ADDR(16'h7400), .ACC_CYC(2), .TMO_CYC(1023)) u_dut (
        .CLK_24M  (CLK_24M),
        .I_RESETn (I_RESETn),
        .CLK_EN   (CLK_EN),
        .bus      (bus_a)
    );

    dkong_vram_cpu_if #(.BASE_ADDR(16'h7400), .ACC_CYC(2), .TMO_CYC(15)) u_dut_tmo (
        .CLK_24M  (CLK_24M),
        .I_RESETn (I_RESETn),
        .CLK_EN   (CLK_EN),
        .bus      (bus_b)
    );

    assign bus_b.I_CPU_AB    = bus_a.I_CPU_AB;
    assign bus_b.I_CPU_DB    = bus_a.I_CPU_DB;
    assign bus_b.I_CPU_MREQn = bus_a.I_CPU_MREQn;
    assign bus_b.I_CPU_RDn   = bus_a.I_CPU_RDn;
    assign bus_b.I_CPU_WRn   = bus_a.I_CPU_WRn;
    assign bus_b.I_VRAMBUSYn = bus_a.I_VRAMBUSYn;
    assign bus_b.I_VRAM_DB   = bus_a.I_VRAM_DB;

    always #5 CLK_24M = ~CLK_24M;

    // VRAM model: synchronous write, read data one clock after the address
    always @(posedge CLK_24M) begin
        if (pre_we) vram_mem[pre_a] <= pre_d;
        if (!bus_a.O_VRAM_WRn) vram_mem[bus_a.O_VRAM_AB] <= bus_a.O_VRAM_DB;
        if (!bus_a.O_VRAM_RDn) bus_a.I_VRAM_DB <= vram_mem[bus_a.O_VRAM_AB];
    end

    task automatic tick();
        @(posedge CLK_24M);
        #1;
        cyc++;
        CLK_EN = slow ? (cyc % 4 == 0) : 1'b1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run the pending request until WAITn returns high, counting strobe clocks
    task automatic run_req(input int max_ticks, output int w_low, output int wr_low,
                           output int rd_low, output logic [9:0] ab,
                           output logic [7:0] db, output bit done);
        w_low = 0; wr_low = 0; rd_low = 0; ab = '0; db = '0; done = 1'b0;
        for (int i = 0; i < max_ticks; i++) begin
            tick();
            if (!bus_a.O_VRAM_WRn) begin
                wr_low++;
                ab = bus_a.O_VRAM_AB;
                db = bus_a.O_VRAM_DB;
            end
            if (!bus_a.O_VRAM_RDn) begin
                rd_low++;
                ab = bus_a.O_VRAM_AB;
            end
            if (bus_a.O_CPU_WAITn) begin
                done = 1'b1;
                break;
            end
            w_low++;
        end
    endtask

    task automatic cpu_req(input logic [15:0] ab, input logic [7:0] db, input logic wr);
        bus_a.I_CPU_AB    = ab;
        bus_a.I_CPU_DB    = db;
        bus_a.I_CPU_WRn   = !wr;
        bus_a.I_CPU_RDn   = wr;
        bus_a.I_CPU_MREQn = 1'b0;
        #1;
    endtask

    task automatic cpu_release();
        bus_a.I_CPU_MREQn = 1'b1;
        bus_a.I_CPU_RDn   = 1'b1;
        bus_a.I_CPU_WRn   = 1'b1;
        bus_a.I_CPU_AB    = 16'h0000;
        bus_a.I_CPU_DB    = 8'h00;
        repeat (slow ? 8 : 2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w, wr, rd, bad, n;
        logic [9:0] ab;
        logic [7:0] db;
        bit         done, found;

        I_RESETn          = 1'b0;
        CLK_EN            = 1'b1;
        pre_we            = 1'b0;
        pre_a             = '0;
        pre_d             = '0;
        bus_a.I_CPU_AB    = 16'h0000;
        bus_a.I_CPU_DB    = 8'h00;
        bus_a.I_CPU_MREQn = 1'b1;
        bus_a.I_CPU_RDn   = 1'b1;
        bus_a.I_CPU_WRn   = 1'b1;
        bus_a.I_VRAMBUSYn = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_waitn",   16'(bus_a.O_CPU_WAITn), 16'h1);
        check("rst_wrn",     16'(bus_a.O_VRAM_WRn),  16'h1);
        check("rst_rdn",     16'(bus_a.O_VRAM_RDn),  16'h1);
        check("rst_vram_ab", 16'(bus_a.O_VRAM_AB),   16'h0);
        check("rst_vram_db", 16'(bus_a.O_VRAM_DB),   16'h0);
        check("rst_cpu_db",  16'(bus_a.O_CPU_DB),    16'h0);
        check("rst_tmo",     16'(bus_a.O_TMO),       16'h0);
        I_RESETn = 1'b1;
        tick();

        // Write with the bus free
        cpu_req(16'h7405, 8'hA5, 1'b1);
        check("wr_wait_comb", 16'(bus_a.O_CPU_WAITn), 16'h0);
        run_req(10, w, wr, rd, ab, db, done);
        check("wr_done",     16'(done), 16'h1);
        check("wr_wait_len", 16'(w),    16'd3);
        check("wr_strb_len", 16'(wr),   16'd2);
        check("wr_no_rd",    16'(rd),   16'd0);
        check("wr_ab",       16'(ab),   16'h005);
        check("wr_db",       16'(db),   16'hA5);
        cpu_release();
        check("wr_mem",      16'(vram_mem[5]),       16'hA5);
        check("wr_db_idle",  16'(bus_a.O_VRAM_DB),   16'h00);
        check("wr_ab_hold",  16'(bus_a.O_VRAM_AB),   16'h005);

        // Misses just outside the window
        cpu_req(16'h7800, 8'hFF, 1'b1);
        check("miss_hi_waitn", 16'(bus_a.O_CPU_WAITn), 16'h1);
        bad = 0;
        repeat (6) begin
            tick();
            if (!bus_a.O_VRAM_WRn || !bus_a.O_VRAM_RDn || !bus_a.O_CPU_WAITn) bad++;
        end
        check("miss_hi_quiet", 16'(bad), 16'd0);
        cpu_release();
        cpu_req(16'h73FF, 8'h00, 1'b0);
        check("miss_lo_waitn", 16'(bus_a.O_CPU_WAITn), 16'h1);
        bad = 0;
        repeat (6) begin
            tick();
            if (!bus_a.O_VRAM_WRn || !bus_a.O_VRAM_RDn || !bus_a.O_CPU_WAITn) bad++;
        end
        check("miss_lo_quiet", 16'(bad), 16'd0);
        cpu_release();

        // Read held off by the video side for 40 cycles
        pre_a = 10'h3FF; pre_d = 8'h5C; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
        bus_a.I_VRAMBUSYn = 1'b0;
        cpu_req(16'h77FF, 8'h00, 1'b0);
        check("rdb_wait_comb", 16'(bus_a.O_CPU_WAITn), 16'h0);
        bad = 0;
        repeat (40) begin
            tick();
            if (bus_a.O_CPU_WAITn || !bus_a.O_VRAM_RDn || !bus_a.O_VRAM_WRn) bad++;
        end
        check("rdb_held",      16'(bad),         16'd0);
        check("rdb_no_tmo",    16'(bus_a.O_TMO), 16'h0);
        check("rdb_short_tmo", 16'(bus_b.O_TMO), 16'h1);
        bus_a.I_VRAMBUSYn = 1'b1;
        run_req(10, w, wr, rd, ab, db, done);
        check("rdb_done",     16'(done),            16'h1);
        check("rdb_strb_len", 16'(rd),              16'd2);
        check("rdb_no_wr",    16'(wr),              16'd0);
        check("rdb_ab",       16'(ab),              16'h3FF);
        check("rdb_data",     16'(bus_a.O_CPU_DB),  16'h5C);
        repeat (3) tick();
        check("rdb_data_hold", 16'(bus_a.O_CPU_DB), 16'h5C);
        cpu_release();
        check("rdb_data_clr",  16'(bus_a.O_CPU_DB), 16'h00);

        // VRAMBUSYn falls one cycle into ACCESS: the write still completes
        cpu_req(16'h7410, 8'h3C, 1'b1);
        tick();
        tick();
        check("mid_entry_wrn", 16'(bus_a.O_VRAM_WRn), 16'h0);
        bus_a.I_VRAMBUSYn = 1'b0;
        run_req(10, w, wr, rd, ab, db, done);
        check("mid_done",     16'(done),    16'h1);
        check("mid_strb_len", 16'(wr + 1),  16'd2);
        check("mid_ab",       16'(ab),      16'h010);
        check("mid_db",       16'(db),      16'h3C);
        bus_a.I_VRAMBUSYn = 1'b1;
        cpu_release();
        check("mid_mem",       16'(vram_mem[10'h010]), 16'h3C);
        check("tmo_sticky",    16'(bus_b.O_TMO),       16'h1);

        // Reset in the middle of ACCESS
        cpu_req(16'h7420, 8'h66, 1'b1);
        tick();
        tick();
        check("rsta_entry_wrn", 16'(bus_a.O_VRAM_WRn), 16'h0);
        I_RESETn = 1'b0;
        #1;
        check("rsta_wrn",   16'(bus_a.O_VRAM_WRn),  16'h1);
        check("rsta_rdn",   16'(bus_a.O_VRAM_RDn),  16'h1);
        check("rsta_waitn", 16'(bus_a.O_CPU_WAITn), 16'h1);
        check("rsta_ab",    16'(bus_a.O_VRAM_AB),   16'h0);
        check("rsta_tmo",   16'(bus_b.O_TMO),       16'h0);
        cpu_release();
        I_RESETn = 1'b1;
        tick();

        // CLK_EN at 1-in-4: a 2-enable strobe spans 8 clocks
        slow = 1'b1;
        cpu_req(16'h7440, 8'h99, 1'b1);
        run_req(64, w, wr, rd, ab, db, done);
        check("slow_done",     16'(done), 16'h1);
        check("slow_strb_len", 16'(wr),   16'd8);
        check("slow_ab",       16'(ab),   16'h040);
        check("slow_db",       16'(db),   16'h99);
        cpu_release();
        slow   = 1'b0;
        CLK_EN = 1'b1;
        tick();

        // Timeout with VRAMBUSYn held low on the short-timeout instance
        bus_a.I_VRAMBUSYn = 1'b0;
        cpu_req(16'h7430, 8'h77, 1'b1);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus_b.O_TMO) begin
                found = 1'b1;
                break;
            end
        end
        check("tmo_fired",   16'(found),                16'h1);
        check("tmo_window",  16'((n >= 15) && (n <= 18)), 16'h1);
        check("tmo_forced",  16'(bus_b.O_VRAM_WRn),     16'h0);
        check("tmo_long_no", 16'(bus_a.O_TMO),          16'h0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_b.O_CPU_WAITn) begin
                found = 1'b1;
                break;
            end
        end
        check("tmo_finish", 16'(found), 16'h1);
        bus_a.I_VRAMBUSYn = 1'b1;
        cpu_release();
        repeat (4) tick();
        check("tmo_stays", 16'(bus_b.O_TMO), 16'h1);
        I_RESETn = 1'b0;
        #1;
        check("tmo_rst_clr", 16'(bus_b.O_TMO), 16'h0);
        tick();
        I_RESETn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
